// File: rtl/branch_checkpoint_manager.sv
// ============================================================================
// Module      : branch_checkpoint_manager
// Description : In-order ring of rename checkpoints with mispredict recovery.
//               Optional perf counters are built when CKPT_PERF_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_checkpoint_manager #(
  parameter int CHECKPOINT_COUNT = 8,
  parameter int CP_BITS          = $clog2(CHECKPOINT_COUNT),
  parameter int DRAIN_CYCLES     = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alloc_req,
  output logic               alloc_grant,
  output logic [CP_BITS-1:0] alloc_id,
  output logic               ckpt_stall,
  input  logic               resolve_valid,
  input  logic [CP_BITS-1:0] resolve_id,
  input  logic               resolve_mispredict,
  input  logic               ext_flush,
  output logic               flush,
  output logic [CP_BITS-1:0] flush_checkpoint,
  output logic               recovering,
  output logic [CP_BITS:0]   free_count,
  output logic [31:0]        perf_mispredicts,
  output logic [31:0]        perf_stall_cycles
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLUSH = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  localparam logic [CP_BITS:0] FULL_FREE  = (CP_BITS+1)'(CHECKPOINT_COUNT);
  localparam logic [3:0]       DRAIN_LOAD = (DRAIN_CYCLES > 0) ? 4'(DRAIN_CYCLES - 1) : 4'd0;

  state_e                      state_q, state_d;
  logic [CHECKPOINT_COUNT-1:0] live_q, live_d;
  logic [CHECKPOINT_COUNT-1:0] resolved_q, resolved_d;
  logic [CP_BITS-1:0]          head_q, head_d;
  logic [CP_BITS-1:0]          tail_q, tail_d;
  logic [CP_BITS-1:0]          x_q, x_d;
  logic [CP_BITS:0]            free_q, free_d;
  logic [3:0]                  drain_q, drain_d;

  logic [CP_BITS-1:0] w_age_rid;
  logic [CP_BITS-1:0] w_age_x;
  logic               w_rid_live;
  logic               w_mis_now;
  logic               w_good_res;
  logic               w_retire;
  logic               w_grant;

  assign w_age_rid  = resolve_id - head_q;
  assign w_age_x    = x_q - head_q;
  assign w_rid_live = live_q[resolve_id];
  // While recovering, only a branch older than the pending one may redirect.
  assign w_mis_now  = resolve_valid & resolve_mispredict & w_rid_live &
                      ((state_q == S_IDLE) | (w_age_rid < w_age_x));
  assign w_good_res = resolve_valid & ~resolve_mispredict & w_rid_live;
  assign w_retire   = live_q[head_q] & resolved_q[head_q] & ~w_mis_now;
  assign w_grant    = alloc_req & (state_q == S_IDLE) & (free_q != '0) &
                      ~w_mis_now & ~ext_flush;

  assign alloc_grant      = w_grant;
  assign alloc_id         = tail_q;
  assign ckpt_stall       = alloc_req & ~w_grant;
  assign flush            = (state_q == S_FLUSH);
  assign flush_checkpoint = x_q;
  assign recovering       = (state_q != S_IDLE);
  assign free_count       = free_q;

  always_comb begin
    state_d    = state_q;
    live_d     = live_q;
    resolved_d = resolved_q;
    head_d     = head_q;
    tail_d     = tail_q;
    x_d        = x_q;
    free_d     = free_q;
    drain_d    = drain_q;

    case (state_q)
      S_FLUSH: begin
        state_d = (DRAIN_CYCLES > 0) ? S_DRAIN : S_IDLE;
        drain_d = DRAIN_LOAD;
      end
      S_DRAIN: begin
        if (drain_q == 4'd0) state_d = S_IDLE;
        else                 drain_d = drain_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase

    if (w_mis_now) begin
      for (int i = 0; i < CHECKPOINT_COUNT; i++) begin
        if ((CP_BITS'(i) - head_q) > w_age_rid) begin
          live_d[i]     = 1'b0;
          resolved_d[i] = 1'b0;
        end
      end
      resolved_d[resolve_id] = 1'b1;
      tail_d  = resolve_id + CP_BITS'(1);
      x_d     = resolve_id;
      free_d  = FULL_FREE - {1'b0, w_age_rid} - (CP_BITS+1)'(1);
      state_d = S_FLUSH;
    end else begin
      if (w_good_res) resolved_d[resolve_id] = 1'b1;
      if (w_retire) begin
        live_d[head_q]     = 1'b0;
        resolved_d[head_q] = 1'b0;
        head_d             = head_q + CP_BITS'(1);
      end
      if (w_grant) begin
        live_d[tail_q]     = 1'b1;
        resolved_d[tail_q] = 1'b0;
        tail_d             = tail_q + CP_BITS'(1);
      end
      free_d = free_q + {{CP_BITS{1'b0}}, w_retire} - {{CP_BITS{1'b0}}, w_grant};
    end

    if (ext_flush) begin
      state_d    = S_IDLE;
      live_d     = '0;
      resolved_d = '0;
      head_d     = '0;
      tail_d     = '0;
      free_d     = FULL_FREE;
      drain_d    = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      live_q     <= '0;
      resolved_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      x_q        <= '0;
      free_q     <= FULL_FREE;
      drain_q    <= 4'd0;
    end else begin
      state_q    <= state_d;
      live_q     <= live_d;
      resolved_q <= resolved_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      x_q        <= x_d;
      free_q     <= free_d;
      drain_q    <= drain_d;
    end
  end

`ifdef CKPT_PERF_CNT_EN
  logic [31:0] perf_mis_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_mis_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      if (w_mis_now && !ext_flush && perf_mis_q != 32'hFFFF_FFFF)
        perf_mis_q <= perf_mis_q + 32'd1;
      if (ckpt_stall && perf_stall_q != 32'hFFFF_FFFF)
        perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_mispredicts  = perf_mis_q;
  assign perf_stall_cycles = perf_stall_q;
`else
  assign perf_mispredicts  = 32'd0;
  assign perf_stall_cycles = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_checkpoint_manager.sv
// Directed self-checking bench for branch_checkpoint_manager (8 slots, 1 drain cycle).
`default_nettype none

module tb_branch_checkpoint_manager;

  logic       clk;
  logic       rst;
  logic       alloc_req;
  logic       alloc_grant;
  logic [2:0] alloc_id;
  logic       ckpt_stall;
  logic       resolve_valid;
  logic [2:0] resolve_id;
  logic       resolve_mispredict;
  logic       ext_flush;
  logic       flush;
  logic [2:0] flush_checkpoint;
  logic       recovering;
  logic [3:0] free_count;
  logic [31:0] perf_mispredicts;
  logic [31:0] perf_stall_cycles;

  int n_checks;
  int n_fail;

  branch_checkpoint_manager #(
    .CHECKPOINT_COUNT(8),
    .DRAIN_CYCLES(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .alloc_req(alloc_req),
    .alloc_grant(alloc_grant),
    .alloc_id(alloc_id),
    .ckpt_stall(ckpt_stall),
    .resolve_valid(resolve_valid),
    .resolve_id(resolve_id),
    .resolve_mispredict(resolve_mispredict),
    .ext_flush(ext_flush),
    .flush(flush),
    .flush_checkpoint(flush_checkpoint),
    .recovering(recovering),
    .free_count(free_count),
    .perf_mispredicts(perf_mispredicts),
    .perf_stall_cycles(perf_stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs change here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alloc_req = 0; resolve_valid = 0; resolve_id = 0;
    resolve_mispredict = 0; ext_flush = 0;
  endtask

  task automatic do_ext_flush();
    idle_inputs();
    ext_flush = 1;
    tick();
    ext_flush = 0;
  endtask

  task automatic alloc_n(input int n);
    for (int i = 0; i < n; i++) begin
      alloc_req = 1;
      #2;
      n_checks++;
      if (alloc_grant !== 1'b1 || alloc_id !== 3'(i)) begin
        n_fail++;
        $display("FAIL alloc_seq[%0d]: grant=%b id=%0d, required grant=1 id=%0d", i, alloc_grant, alloc_id, i);
      end
      tick();
    end
    alloc_req = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    tick(); tick();
    rst = 0;
    n_checks++;
    if (flush !== 1'b0 || flush_checkpoint !== 3'd0 || recovering !== 1'b0 ||
        free_count !== 4'd8 || alloc_id !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_state: flush=%b fc=%0d rec=%b free=%0d id=%0d, required 0 0 0 8 0",
               flush, flush_checkpoint, recovering, free_count, alloc_id);
    end
    n_checks++;
    if (perf_mispredicts !== 32'd0 || perf_stall_cycles !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_perf: mis=%0d stall=%0d, required 0 0", perf_mispredicts, perf_stall_cycles);
    end
  endtask

  task automatic test_full_ring();
    alloc_n(8);
    alloc_req = 1;
    #2;
    n_checks++;
    if (alloc_grant !== 1'b0 || ckpt_stall !== 1'b1 || free_count !== 4'd0) begin
      n_fail++;
      $display("FAIL full_stall: grant=%b stall=%b free=%0d, required 0 1 0", alloc_grant, ckpt_stall, free_count);
    end
    resolve_valid = 1; resolve_id = 0; resolve_mispredict = 0;
    tick();
    resolve_valid = 0;
    tick();
    #2;
    n_checks++;
    if (alloc_grant !== 1'b1 || alloc_id !== 3'd0 || free_count !== 4'd1) begin
      n_fail++;
      $display("FAIL wrap_grant: grant=%b id=%0d free=%0d, required 1 0 1", alloc_grant, alloc_id, free_count);
    end
    tick();
    alloc_req = 0;
    n_checks++;
    if (free_count !== 4'd0) begin
      n_fail++;
      $display("FAIL wrap_free: free=%0d, required 0", free_count);
    end
    do_ext_flush();
  endtask

  task automatic test_mispredict();
    alloc_n(5);
    resolve_valid = 1; resolve_id = 2; resolve_mispredict = 1;
    tick();
    idle_inputs();
    alloc_req = 1;
    #2;
    n_checks++;
    if (flush !== 1'b1 || flush_checkpoint !== 3'd2 || recovering !== 1'b1 ||
        free_count !== 4'd5 || alloc_grant !== 1'b0) begin
      n_fail++;
      $display("FAIL mis_flush: flush=%b fc=%0d rec=%b free=%0d grant=%b, required 1 2 1 5 0",
               flush, flush_checkpoint, recovering, free_count, alloc_grant);
    end
    tick();
    #2;
    n_checks++;
    if (flush !== 1'b0 || recovering !== 1'b1 || alloc_grant !== 1'b0) begin
      n_fail++;
      $display("FAIL mis_drain: flush=%b rec=%b grant=%b, required 0 1 0", flush, recovering, alloc_grant);
    end
    tick();
    #2;
    n_checks++;
    if (recovering !== 1'b0 || alloc_grant !== 1'b1 || alloc_id !== 3'd3) begin
      n_fail++;
      $display("FAIL mis_regrant: rec=%b grant=%b id=%0d, required 0 1 3", recovering, alloc_grant, alloc_id);
    end
    tick();
    alloc_req = 0;
    n_checks++;
    if (free_count !== 4'd4) begin
      n_fail++;
      $display("FAIL mis_free_after: free=%0d, required 4", free_count);
    end
    do_ext_flush();
  endtask

  task automatic test_back_to_back();
    alloc_n(5);
    resolve_valid = 1; resolve_id = 4; resolve_mispredict = 1;
    tick();
    resolve_id = 1;
    n_checks++;
    if (flush !== 1'b1 || flush_checkpoint !== 3'd4) begin
      n_fail++;
      $display("FAIL b2b_first: flush=%b fc=%0d, required 1 4", flush, flush_checkpoint);
    end
    tick();
    idle_inputs();
    n_checks++;
    if (flush !== 1'b1 || flush_checkpoint !== 3'd1 || free_count !== 4'd6) begin
      n_fail++;
      $display("FAIL b2b_second: flush=%b fc=%0d free=%0d, required 1 1 6", flush, flush_checkpoint, free_count);
    end
    tick();
    n_checks++;
    if (flush !== 1'b0 || recovering !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_drain: flush=%b rec=%b, required 0 1", flush, recovering);
    end
    tick();
    n_checks++;
    if (recovering !== 1'b0 || alloc_id !== 3'd2) begin
      n_fail++;
      $display("FAIL b2b_idle: rec=%b id=%0d, required 0 2", recovering, alloc_id);
    end
    do_ext_flush();
  endtask

  task automatic test_mis_with_alloc();
    alloc_n(4);
    alloc_req = 1;
    resolve_valid = 1; resolve_id = 1; resolve_mispredict = 1;
    #2;
    n_checks++;
    if (alloc_grant !== 1'b0 || ckpt_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL mis_alloc_block: grant=%b stall=%b, required 0 1", alloc_grant, ckpt_stall);
    end
    tick();
    idle_inputs();
    n_checks++;
    if (flush !== 1'b1 || flush_checkpoint !== 3'd1 || free_count !== 4'd6) begin
      n_fail++;
      $display("FAIL mis_alloc_flush: flush=%b fc=%0d free=%0d, required 1 1 6", flush, flush_checkpoint, free_count);
    end
    tick(); tick();
    resolve_valid = 1; resolve_id = 3; resolve_mispredict = 1;
    tick();
    idle_inputs();
    n_checks++;
    if (flush !== 1'b0 || recovering !== 1'b0 || free_count !== 4'd6 || alloc_id !== 3'd2) begin
      n_fail++;
      $display("FAIL squashed_resolve: flush=%b rec=%b free=%0d id=%0d, required 0 0 6 2",
               flush, recovering, free_count, alloc_id);
    end
    do_ext_flush();
  endtask

  task automatic test_in_order_retire();
    alloc_n(4);
    resolve_valid = 1; resolve_mispredict = 0;
    resolve_id = 2; tick();
    resolve_id = 3; tick();
    resolve_valid = 0; tick();
    n_checks++;
    if (free_count !== 4'd4) begin
      n_fail++;
      $display("FAIL no_early_retire: free=%0d, required 4", free_count);
    end
    resolve_valid = 1;
    resolve_id = 0; tick();
    resolve_id = 1; tick();
    resolve_valid = 0;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (free_count !== 4'(5 + k)) begin
        n_fail++;
        $display("FAIL retire_step[%0d]: free=%0d, required %0d", k, free_count, 5 + k);
      end
      if (k < 3) tick();
    end
    do_ext_flush();
  endtask

  task automatic test_ext_flush_drain();
    alloc_n(3);
    resolve_valid = 1; resolve_id = 0; resolve_mispredict = 1;
    tick();
    idle_inputs();
    tick();
    n_checks++;
    if (recovering !== 1'b1 || flush !== 1'b0) begin
      n_fail++;
      $display("FAIL pre_ext_drain: rec=%b flush=%b, required 1 0", recovering, flush);
    end
    ext_flush = 1;
    tick();
    ext_flush = 0;
    n_checks++;
    if (recovering !== 1'b0 || flush !== 1'b0 || free_count !== 4'd8 || alloc_id !== 3'd0) begin
      n_fail++;
      $display("FAIL ext_flush: rec=%b flush=%b free=%0d id=%0d, required 0 0 8 0",
               recovering, flush, free_count, alloc_id);
    end
`ifdef CKPT_PERF_CNT_EN
    n_checks++;
    if (perf_mispredicts !== 32'd5) begin
      n_fail++;
      $display("FAIL perf_mis: count=%0d, required 5", perf_mispredicts);
    end
`else
    n_checks++;
    if (perf_mispredicts !== 32'd0 || perf_stall_cycles !== 32'd0) begin
      n_fail++;
      $display("FAIL perf_tied: mis=%0d stall=%0d, required 0 0", perf_mispredicts, perf_stall_cycles);
    end
`endif
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1;
    idle_inputs();
    test_reset();
    test_full_ring();
    test_mispredict();
    test_back_to_back();
    test_mis_with_alloc();
    test_in_order_retire();
    test_ext_flush_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/branch_checkpoint_manager.md
# branch_checkpoint_manager

Allocates, tracks and retires the rename stage's RAT/free-list checkpoints as an in-order ring.
- On each branch misprediction it picks the checkpoint to restore and drives the rename-stage flush.
- It squashes all younger checkpoints and holds off new allocations until recovery ends.
- It sits between rename (allocation), the branch execution units (resolution) and the ROB (exception flush).

## Interface
- CHECKPOINT_COUNT, 8, number of checkpoint slots; power of two, ≥2
- CP_BITS, $clog2(CHECKPOINT_COUNT), checkpoint id width (derived)
- DRAIN_CYCLES, 1, allocation-blocked cycles after the flush pulse; range 0–15

Clock and reset:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset; synchronous, active-high

Allocation (rename side):
- alloc_req  in  1  rename group contains a branch needing a checkpoint
- alloc_grant  out  1  checkpoint granted this cycle; combinational
- alloc_id  out  CP_BITS  slot granted; always equals tail
- ckpt_stall  out  1  alloc_req present but not granted; combinational

Resolution and ROB:
- resolve_valid  in  1  a branch resolved this cycle
- resolve_id  in  CP_BITS  checkpoint of the resolving branch
- resolve_mispredict  in  1  the resolving branch was mispredicted
- ext_flush  in  1  ROB exception/full flush; discards all checkpoints

Flush output to rename:
- flush  out  1  registered one-cycle pulse: restore the checkpoint
- flush_checkpoint  out  CP_BITS  slot to restore; held while flush=1

Status and counters:
- recovering  out  1  state ≠ IDLE
- free_count  out  CP_BITS+1  free slots; registered
- perf_mispredicts  out  32  mispredict count (macro-gated)
- perf_stall_cycles  out  32  count of cycles with ckpt_stall=1 (macro-gated)

## Operation
- State per slot: live, resolved. Pointers: head (oldest live), tail (next to allocate). count = live slots.
- Age of a slot = (id − head) mod CHECKPOINT_COUNT. Wrap-around is implicit in CP_BITS arithmetic.
- A resolve is accepted only if resolve_id is live. Resolves on non-live ids are ignored.
- Correct resolve: set resolved[id]. Each cycle, if head is live and resolved, clear the slot and advance head.
  - At most one retirement per cycle.
- mis_now = resolve_valid & resolve_mispredict & live[resolve_id].
  - In FLUSH/DRAIN, mis_now additionally requires age(resolve_id) < age(pending X).
- alloc_grant = alloc_req & state==IDLE & count<CHECKPOINT_COUNT & !mis_now.
- Grant: live[tail]=1, resolved[tail]=0, tail+1.
- mis_now on slot X:
  - Clear live for every slot younger than X.
  - Mark X resolved; X stays live until it retires normally.
  - tail ← X+1; latch X; enter FLUSH.
- FSM:
  - IDLE → FLUSH on mis_now.
  - FLUSH (flush=1, flush_checkpoint=X, one cycle) → DRAIN if DRAIN_CYCLES>0, else IDLE.
  - DRAIN counts DRAIN_CYCLES cycles → IDLE.
  - An accepted older mis_now in FLUSH or DRAIN re-latches X and re-enters FLUSH.
- ext_flush: all slots cleared, head=tail=0, state IDLE, no flush pulse, in-flight recovery abandoned. Overrides everything except rst.
- Priority: rst > ext_flush > mis_now > correct resolve/retire > allocation.

## Timing
- alloc_grant, alloc_id and ckpt_stall are same-cycle combinational. Pointer and count updates are visible the next cycle.
- Mispredict resolve in cycle N → flush=1 in cycle N+1. Allocations are blocked in N (by mis_now) and from N+1 through N+1+DRAIN_CYCLES.
- Full ring (count=CHECKPOINT_COUNT): ckpt_stall=1 while alloc_req=1.
  - A retirement in cycle N permits a grant in N+1.
- Retirement and allocation in the same cycle: count unchanged.
- Reset values:
  - head=tail=0, all slots clear, state IDLE.
  - flush=0, flush_checkpoint=0, recovering=0, free_count=CHECKPOINT_COUNT.
  - perf counters 0; alloc_id=0.
- rst mid-recovery aborts the flush pulse. The pulse is never produced after reset deasserts.

## Configuration
- CKPT_PERF_CNT_EN defined: perf_mispredicts increments on each accepted mis_now. perf_stall_cycles increments each cycle ckpt_stall=1. Both saturate at 32'hFFFF_FFFF; cleared by rst only.
- Undefined: both outputs tied to 0 and no counter flops are built. Functional behaviour is otherwise identical.

## Test plan
- Reset, then 8 alloc_req cycles → ids 0..7 granted. 9th cycle: ckpt_stall=1, free_count=0. Resolve id 0 correct → grant of id 0 (wrapped) on the following cycle.
- Allocate 0..4, mispredict id 2 → flush=1, flush_checkpoint=2 next cycle. Slots 3,4 dead; next grant gets id 3 after DRAIN; free_count=5.
- Mispredict id 4 at cycle N, then mispredict id 1 at N+1 → second flush pulse at N+2 with flush_checkpoint=1.
- Mispredict id 1 in the same cycle as alloc_req → alloc_grant=0, ckpt_stall=1. Resolve of squashed id 3 later is ignored.
- Allocate 0..3, resolve 2 and 3 correct → no retirement; resolve 0 and 1 → head advances 0→4 over 4 cycles; free_count=8.
- ext_flush during DRAIN → state IDLE, free_count=8, no flush pulse. With CKPT_PERF_CNT_EN, perf_mispredicts retains its value.
